// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the single-bit sequence detectors it feeds.
package seq_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = STATE_IDLE,
        SHIFT = STATE_SHIFT
    } state_e;

    // Line level between words; drives detectors back to their start state.
    localparam logic       BIT_IDLE    = 1'b0;
    localparam logic [3:0] PAT_1110    = 4'b1110;
    localparam int         PAT_1110_W  = 4;

endpackage

// File: rtl/seq_serializer_msb_if.sv
// Parallel word in (val/rdy) and serial bit stream out.
interface seq_serializer_msb_if #(parameter int nbits = 8);

    logic [nbits-1:0] in_;
    logic             in_val;
    logic             in_rdy;
    logic             out;
    logic             out_val;

    modport master (output in_, output in_val, input in_rdy, input out, input out_val);
    modport slave  (input in_, input in_val, output in_rdy, output out, output out_val);

endinterface

// File: rtl/seq_serializer_msb.sv
// MSB-first parallel-to-serial stage; reloads on the last bit for back-to-back words.
module seq_serializer_msb
    import seq_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_serializer_msb_if.slave  bus
);

    localparam int              CW   = $clog2(nbits);
    localparam logic [CW-1:0]   LAST = CW'(nbits - 1);

    state_e           state, state_nx;
    logic [nbits-1:0] shreg, shreg_nx;
    logic [CW-1:0]    count, count_nx;
    logic             rdy;
    logic             xfer;

    // count==0 in SHIFT means the final bit is on the line, so a new word may load now.
    assign rdy         = !reset && (state == IDLE || count == '0);
    assign xfer        = bus.in_val && rdy;
    assign bus.in_rdy  = rdy;
    assign bus.out     = (state == SHIFT) ? shreg[nbits-1] : BIT_IDLE;
    assign bus.out_val = (state == SHIFT);

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        count_nx = count;
        case (state)
            IDLE: begin
                if (xfer) begin
                    shreg_nx = bus.in_;
                    count_nx = LAST;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (count != '0) begin
                    shreg_nx = shreg << 1;
                    count_nx = count - 1'b1;
                end else if (xfer) begin
                    shreg_nx = bus.in_;
                    count_nx = LAST;
                end else begin
                    state_nx = IDLE;
                    shreg_nx = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            count <= count_nx;
        end
    end

endmodule

// File: tb/tb_seq_serializer_msb.sv
// Directed bench for the serializer: 8-bit and 2-bit builds sharing clock and reset.
module tb_seq_serializer_msb;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    seq_serializer_msb_if #(.nbits(8)) b8 ();
    seq_serializer_msb_if #(.nbits(2)) b2 ();

    seq_serializer_msb #(.nbits(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    seq_serializer_msb #(.nbits(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle on the 8-bit DUT: drive just after posedge, check at negedge.
    task automatic cyc8(input string tag, input logic v, input logic [7:0] d,
                        input logic eo, input logic ev, input logic er);
        b8.in_val = v;
        b8.in_    = d;
        #4;
        chk({tag, ".out"},     32'(b8.out),     32'(eo));
        chk({tag, ".out_val"}, 32'(b8.out_val), 32'(ev));
        chk({tag, ".in_rdy"},  32'(b8.in_rdy),  32'(er));
        @(posedge clk); #1;
    endtask

    task automatic cyc2(input string tag, input logic v, input logic [1:0] d,
                        input logic eo, input logic ev, input logic er);
        b2.in_val = v;
        b2.in_    = d;
        #4;
        chk({tag, ".out"},     32'(b2.out),     32'(eo));
        chk({tag, ".out_val"}, 32'(b2.out_val), 32'(ev));
        chk({tag, ".in_rdy"},  32'(b2.in_rdy),  32'(er));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] wa, wb;
        reset     = 1'b1;
        b8.in_val = 1'b0;
        b8.in_    = '0;
        b2.in_val = 1'b0;
        b2.in_    = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset asserted: rdy forced low, line idle
        cyc8("rst", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Idle with garbage on in_ and in_val low
        for (int i = 0; i < 20; i++)
            cyc8($sformatf("idle%0d", i), 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1);

        // Single word E0
        cyc8("single.t", 1'b1, 8'hE0, 1'b0, 1'b0, 1'b1);
        wa = 8'hE0;
        for (int i = 0; i < 8; i++)
            cyc8($sformatf("single.b%0d", i), 1'b0, 8'h00, wa[7-i], 1'b1, i == 7);
        cyc8("single.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Back-to-back FF then 00, no bubble
        cyc8("b2b.t", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            cyc8($sformatf("b2b.a%0d", i), 1'b1, 8'h00, 1'b1, 1'b1, i == 7);
        for (int i = 0; i < 8; i++)
            cyc8($sformatf("b2b.b%0d", i), 1'b0, 8'h00, 1'b0, 1'b1, i == 7);
        cyc8("b2b.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure: B presented at t+3, held until accepted at t+8
        wa = 8'hA5;
        wb = 8'h3C;
        cyc8("bp.t", 1'b1, wa, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            cyc8($sformatf("bp.a%0d", i), i >= 2, (i >= 2) ? wb : 8'h00, wa[7-i], 1'b1, i == 7);
        for (int i = 0; i < 8; i++)
            cyc8($sformatf("bp.b%0d", i), 1'b0, 8'h00, wb[7-i], 1'b1, i == 7);
        cyc8("bp.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset mid-word
        cyc8("mid.t", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc8($sformatf("mid.b%0d", i), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        cyc8("mid.rst", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        wa = 8'h80;
        cyc8("mid.new", 1'b1, wa, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            cyc8($sformatf("mid.n%0d", i), 1'b0, 8'h00, wa[7-i], 1'b1, i == 7);
        cyc8("mid.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 2-bit build: 10 then 01 back-to-back -> 1,0,0,1
        cyc2("n2.t",  1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc2("n2.c1", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        cyc2("n2.c2", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
        cyc2("n2.c3", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc2("n2.c4", 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        cyc2("n2.end", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
